// File: rtl/mux_tree_pipe.sv
// ============================================================================
// mux_tree_pipe : pipelined NUM_INPUTS:1 radix-RADIX mux tree, valid/ready,
//                 out-of-range select flag. Option: MUX_TREE_PIPE_STICKY_ERR_EN
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mux_tree_pipe #(
  parameter int BIT_WIDTH  = 16,
  parameter int NUM_INPUTS = 81,
  parameter int SEL_WIDTH  = 7,
  parameter int RADIX      = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_INPUTS*BIT_WIDTH-1:0] i_A,
  input  logic [SEL_WIDTH-1:0]            i_sel,
  input  logic                            i_valid,
  output logic                            o_ready,
  output logic [BIT_WIDTH-1:0]            o_B,
  output logic                            o_sel_err,
  output logic                            o_valid,
  input  logic                            i_ready
`ifdef MUX_TREE_PIPE_STICKY_ERR_EN
  ,
  input  logic                            i_err_clr,
  output logic                            o_err_sticky
`endif
);

  function automatic int calc_levels();
    int    l;
    longint p;
    l = 1;
    p = RADIX;
    while (p < NUM_INPUTS) begin
      p = p * RADIX;
      l++;
    end
    return l;
  endfunction

  localparam int C_LOG_R   = $clog2(RADIX);
  localparam int LEVELS    = calc_levels();
  localparam int C_SEL_PAD = LEVELS * C_LOG_R;
  localparam int C_PAD_N   = 1 << C_SEL_PAD;

  logic [C_PAD_N*BIT_WIDTH-1:0] a_pad;
  logic [C_SEL_PAD-1:0]         sel_pad;
  logic                         sel_err;

  assign a_pad   = (C_PAD_N*BIT_WIDTH)'(i_A);
  assign sel_pad = C_SEL_PAD'(i_sel);
  assign sel_err = ({1'b0, i_sel} >= (SEL_WIDTH+1)'(NUM_INPUTS));

  logic [LEVELS-1:0] vld_q;
  logic [LEVELS-1:0] vld_d;
  logic [LEVELS-1:0] vld_in;
  logic [LEVELS-1:0] stage_rdy;

  // Stage s is fed by stage s-1 (stage 0 by the input port).
  assign vld_in = LEVELS'({vld_q, i_valid});

  // ready_s = !v_s || ready_(s+1), unrolled from the output end.
  always_comb begin : p_ready
    logic acc;
    acc = i_ready;
    stage_rdy = '0;
    for (int s = LEVELS - 1; s >= 0; s--) begin
      acc          = acc || !vld_q[s];
      stage_rdy[s] = acc;
    end
    vld_d = (stage_rdy & vld_in) | (~stage_rdy & vld_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  for (genvar s = 0; s < LEVELS; s++) begin : g_stage
    localparam int NW_IN  = 1 << (C_LOG_R * (LEVELS - s));
    localparam int NW_OUT = NW_IN / RADIX;
    localparam int SW_IN  = C_LOG_R * (LEVELS - s);

    logic [NW_IN*BIT_WIDTH-1:0]  din;
    logic [SW_IN-1:0]            sin;
    logic                        ein;
    logic                        ld;
    logic [C_LOG_R-1:0]          digit;
    logic [NW_OUT*BIT_WIDTH-1:0] data_d;
    logic [NW_OUT*BIT_WIDTH-1:0] data_q;
    logic                        err_q;

    if (s == 0) begin : g_src_in
      assign din = a_pad;
      assign sin = sel_pad;
      assign ein = sel_err;
    end else begin : g_src_prev
      assign din = g_stage[s-1].data_q;
      assign sin = g_stage[s-1].g_sel.sel_q;
      assign ein = g_stage[s-1].err_q;
    end

    assign ld    = stage_rdy[s] && vld_in[s];
    assign digit = sin[C_LOG_R-1:0];

    always_comb begin
      data_d = '0;
      for (int m = 0; m < NW_OUT; m++) begin
        data_d[m*BIT_WIDTH +: BIT_WIDTH] =
          din[(m*RADIX + int'(digit))*BIT_WIDTH +: BIT_WIDTH];
      end
      if (s == LEVELS - 1 && ein) begin
        data_d = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        err_q <= 1'b0;
      end else if (ld) begin
        err_q <= ein;
      end
    end

    // Only the output word is reset so o_B reads 0 out of reset.
    if (s == LEVELS - 1) begin : g_dat_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
        end else if (ld) begin
          data_q <= data_d;
        end
      end
    end else begin : g_dat_nrst
      always_ff @(posedge clk) begin
        if (ld) begin
          data_q <= data_d;
        end
      end
    end

    if (s < LEVELS - 1) begin : g_sel
      logic [SW_IN-C_LOG_R-1:0] sel_d;
      logic [SW_IN-C_LOG_R-1:0] sel_q;

      always_comb begin
        sel_d = sin[SW_IN-1:C_LOG_R];
      end

      always_ff @(posedge clk) begin
        if (ld) begin
          sel_q <= sel_d;
        end
      end
    end
  end

  assign o_valid   = vld_q[LEVELS-1];
  assign o_ready   = stage_rdy[0];
  assign o_B       = g_stage[LEVELS-1].data_q;
  assign o_sel_err = g_stage[LEVELS-1].err_q;

`ifdef MUX_TREE_PIPE_STICKY_ERR_EN
  logic err_sticky_d;
  logic err_sticky_q;

  // A set in the same cycle as a clear takes priority.
  always_comb begin
    err_sticky_d = err_sticky_q;
    if (i_err_clr) begin
      err_sticky_d = 1'b0;
    end
    if (o_valid && i_ready && o_sel_err) begin
      err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign o_err_sticky = err_sticky_q;
`endif

endmodule

`default_nettype wire
